// File: rtl/alu_pkg.sv
// Shared opcode encodings, flag bit positions and small decode helpers for alu_seq.
// The multiplier opcode is only implemented when ALU_MUL_EN is defined.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'b000;
  localparam op_t OP_SUB = 3'b001;
  localparam op_t OP_ADC = 3'b010;
  localparam op_t OP_SBB = 3'b011;
  localparam op_t OP_AND = 3'b100;
  localparam op_t OP_OR  = 3'b101;
  localparam op_t OP_XOR = 3'b110;
  localparam op_t OP_MUL = 3'b111;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;

  // Opcodes 000..011 share the single adder.
  function automatic logic op_is_arith(input op_t op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic op_inverts_b(input op_t op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per clock, WIDTH steps.
// fin/prod are valid on the edge that completes the last step (only built with ALU_MUL_EN).
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               go,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               fin,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // Load operands on go, otherwise advance one shift-add step while busy.
  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (busy_q) begin
      acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      busy_d   = (cnt_q != CNT_W'(1));
    end else if (go) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
      busy_d   = 1'b1;
    end else begin
      busy_d   = 1'b0;
    end
  end

  // Operand, accumulator and counter state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign busy = busy_q;
  assign fin  = busy_q && (cnt_q == CNT_W'(1));
  assign prod = acc_d;

endmodule

// File: rtl/alu_seq.sv
// Parametrised ALU with carry-chained arithmetic, logic ops and a C/Z/N/V flag register.
// Define ALU_MUL_EN to build the multi-cycle unsigned multiplier for opcode 111.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             oe,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             cf,
  output logic             zf,
  output logic             nf,
  output logic             vf
);

  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [3:0]         flg_q, flg_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   bx_s, logic_s;
  logic               cin_s;
  logic [WIDTH:0]     sum_s;
  logic               accept_s;
  logic               mul_busy_s, mul_fin_s;
  logic [2*WIDTH-1:0] mul_prod_s;

  assign accept_s = start && !mul_busy_s;

`ifdef ALU_MUL_EN
  logic mul_go_s;
  assign mul_go_s = accept_s && (op == OP_MUL);

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk  (clk),
    .clr  (clr),
    .go   (mul_go_s),
    .a    (a),
    .b    (b),
    .busy (mul_busy_s),
    .fin  (mul_fin_s),
    .prod (mul_prod_s)
  );
`else
  logic [CNT_W-1:0] unused_cnt_s;
  assign unused_cnt_s = '0;
  assign mul_busy_s   = 1'b0;
  assign mul_fin_s    = 1'b0;
  assign mul_prod_s   = '0;
`endif

  // Adder operand/carry-in selection and the bitwise results.
  always_comb begin
    bx_s = op_inverts_b(op) ? ~b : b;
    case (op)
      OP_SUB:         cin_s = 1'b1;
      OP_ADC, OP_SBB: cin_s = flg_q[FLG_C];
      default:        cin_s = 1'b0;
    endcase
    case (op)
      OP_AND:  logic_s = a & b;
      OP_OR:   logic_s = a | b;
      OP_XOR:  logic_s = a ^ b;
      default: logic_s = '0;
    endcase
  end

  assign sum_s = {1'b0, a} + {1'b0, bx_s} + {{WIDTH{1'b0}}, cin_s};

  // Result, high word, flags and done for the coming edge.
  always_comb begin
    res_d  = res_q;
    hi_d   = hi_q;
    flg_d  = flg_q;
    done_d = 1'b0;
    if (mul_fin_s) begin
      res_d        = mul_prod_s[WIDTH-1:0];
      hi_d         = mul_prod_s[2*WIDTH-1:WIDTH];
      flg_d[FLG_C] = |mul_prod_s[2*WIDTH-1:WIDTH];
      flg_d[FLG_Z] = ~|mul_prod_s;
      flg_d[FLG_N] = mul_prod_s[WIDTH-1];
      flg_d[FLG_V] = 1'b0;
      done_d       = 1'b1;
    end else if (accept_s && op_is_arith(op)) begin
      res_d        = sum_s[WIDTH-1:0];
      hi_d         = '0;
      flg_d[FLG_C] = sum_s[WIDTH];
      flg_d[FLG_Z] = ~|sum_s[WIDTH-1:0];
      flg_d[FLG_N] = sum_s[WIDTH-1];
      flg_d[FLG_V] = (a[WIDTH-1] == bx_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      done_d       = 1'b1;
    end else if (accept_s && (op != OP_MUL)) begin
      res_d        = logic_s;
      hi_d         = '0;
      flg_d[FLG_C] = 1'b0;
      flg_d[FLG_Z] = ~|logic_s;
      flg_d[FLG_N] = logic_s[WIDTH-1];
      flg_d[FLG_V] = 1'b0;
      done_d       = 1'b1;
    end else if (accept_s) begin
`ifdef ALU_MUL_EN
      // The multiplier owns the result until its final step.
      done_d = 1'b0;
`else
      res_d  = '0;
      hi_d   = '0;
      done_d = 1'b1;
`endif
    end else begin
      done_d = 1'b0;
    end
  end

  // Architectural result/flag register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      res_q  <= '0;
      hi_q   <= '0;
      flg_q  <= 4'b0000;
      done_q <= 1'b0;
    end else begin
      res_q  <= res_d;
      hi_q   <= hi_d;
      flg_q  <= flg_d;
      done_q <= done_d;
    end
  end

  assign out  = oe ? res_q : {WIDTH{1'bz}};
  assign hi   = hi_q;
  assign busy = mul_busy_s;
  assign done = done_q;
  assign cf   = flg_q[FLG_C];
  assign zf   = flg_q[FLG_Z];
  assign nf   = flg_q[FLG_N];
  assign vf   = flg_q[FLG_V];

endmodule
